// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot sequencer: FSM states, cpu_rst mode
// encodings and the default code-image size limit.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_GAP,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [1:0] CPU_HOLD = 2'b00;
  localparam logic [1:0] CPU_LOAD = 2'b01;
  localparam logic [1:0] CPU_RUN  = 2'b11;

  localparam int unsigned MAX_WORDS_DEFAULT = 1024;

  // Width of the length header field and of the word counter.
  localparam int unsigned LEN_W = 11;

endpackage

// File: rtl/cpu_boot_wdog.sv
// Run-time watchdog for the CPU boot sequencer. Counts cycles spent in RUN
// and flags expiry when WDOG_CYCLES-1 is reached without a CPU event.
module cpu_boot_wdog #(
  parameter int unsigned WDOG_CYCLES = 16777216
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic evt,
  output logic expire
);

  localparam int unsigned CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expire = run && !evt && (cnt_q == LAST);

  // Counter runs only in RUN; an event, expiry or leaving RUN clears it.
  always_ff @(posedge clk) begin
    if (rst || !run || evt || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_boot_seq.sv
// CPU boot sequencer: accepts a length header plus a code image, streams it
// into the CPU code RAM over cpu_par with cpu_rst=01, then releases the CPU
// into RUN after a one-cycle hold so the program counter restarts at 0.
// Optional run-time watchdog enabled by defining CPU_BOOT_WDOG_EN.
module cpu_boot_seq
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEFAULT,
  parameter int unsigned WDOG_CYCLES = 16777216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_halt,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        cpu_evt,
  output logic [1:0]  cpu_rst,
  output logic [15:0] cpu_par,
  output logic        running,
  output logic        busy,
  output logic        err,
  output logic        wdog_trip
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rst_d;
  logic [15:0]      par_d;
  logic             rdy_d;
  logic             err_d;
  logic             trip_d;
  logic             accept;
  logic             wdog_expire;
  logic [LEN_W-1:0] hdr_len;

  assign accept  = in_valid && in_ready;
  assign hdr_len = in_data[LEN_W-1:0];

`ifdef CPU_BOOT_WDOG_EN
  cpu_boot_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == ST_RUN),
    .evt    (cpu_evt),
    .expire (wdog_expire)
  );
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
  logic unused_evt;
  assign unused_evt  = cpu_evt;
  assign wdog_expire = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err;
    rst_d   = CPU_HOLD;
    par_d   = '0;
    trip_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdr_len == '0 || hdr_len > MAX_LEN) begin
            state_d = ST_ERR;
          end else begin
            len_d   = hdr_len;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (cnt_q == len_q) begin
          state_d = ST_GAP;
        end else if (accept) begin
          rst_d = CPU_LOAD;
          par_d = in_data;
          cnt_d = cnt_q + LEN_W'(1);
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_GAP: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_start) begin
          state_d = ST_HDR;
        end else if (wdog_expire) begin
          state_d = ST_GAP;
          trip_d  = 1'b1;
        end
      end
      ST_ERR: begin
        if (cmd_start) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd_halt) begin
      state_d = ST_IDLE;
      rst_d   = CPU_HOLD;
      par_d   = '0;
      trip_d  = 1'b0;
      err_d   = err;
    end

    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end
    if (state_d == ST_RUN) begin
      rst_d = CPU_RUN;
    end

    rdy_d = (state_d == ST_HDR) || ((state_d == ST_LOAD) && (cnt_d < len_d));
  end

  // State, counters and all outputs registered with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      cpu_rst   <= CPU_HOLD;
      cpu_par   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      running   <= 1'b0;
      err       <= 1'b0;
      wdog_trip <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cpu_rst   <= rst_d;
      cpu_par   <= par_d;
      in_ready  <= rdy_d;
      busy      <= (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_GAP);
      running   <= (rst_d == CPU_RUN);
      err       <= err_d;
      wdog_trip <= trip_d;
    end
  end

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Self-checking bench for cpu_boot_seq. Directed scenarios push the expected
// output tuple for every cycle into a queue; a compare process checks the DUT
// against it on the falling edge. Watchdog scenarios need CPU_BOOT_WDOG_EN.
module tb_cpu_boot_seq;

  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic        cmd_halt;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        cpu_evt;
  logic [1:0]  cpu_rst;
  logic [15:0] cpu_par;
  logic        running;
  logic        busy;
  logic        err;
  logic        wdog_trip;

  typedef struct packed {
    logic [1:0]  r;
    logic [15:0] par;
    logic        rdy;
    logic        busy;
    logic        run;
    logic        err;
    logic        trip;
  } outs_t;

  typedef struct {
    int    due;
    string tag;
    outs_t o;
  } exp_t;

  exp_t        q[$];
  logic [15:0] img[$];
  logic [15:0] par_log[$];
  int          cyc = 0;
  int          ntests = 0;
  int          nfail = 0;
  int          n01 = 0;

  cpu_boot_seq #(
    .MAX_WORDS   (MAXW),
    .WDOG_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cmd_halt  (cmd_halt),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_evt   (cpu_evt),
    .cpu_rst   (cpu_rst),
    .cpu_par   (cpu_par),
    .running   (running),
    .busy      (busy),
    .err       (err),
    .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t mk(logic [1:0] r, logic [15:0] par, logic rdy,
                               logic bsy, logic run, logic e, logic trip);
    outs_t o;
    o.r = r; o.par = par; o.rdy = rdy; o.busy = bsy;
    o.run = run; o.err = e; o.trip = trip;
    return o;
  endfunction

  function automatic outs_t e_idle(logic e);     return mk(2'b00, 16'h0, 1'b0, 1'b0, 1'b0, e, 1'b0);    endfunction
  function automatic outs_t e_hdr();             return mk(2'b00, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
  function automatic outs_t e_loadw();           return mk(2'b00, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
  function automatic outs_t e_w(logic [15:0] p, logic rdy); return mk(2'b01, p, rdy, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
  function automatic outs_t e_gap(logic trip);   return mk(2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, trip); endfunction
  function automatic outs_t e_run();             return mk(2'b11, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endfunction
  function automatic outs_t e_err();             return mk(2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endfunction

  task automatic chk(string name, int got, int want);
    ntests++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Register the expectation for the next cycle, then advance one clock.
  task automatic step(string tag, outs_t e);
    exp_t x;
    x.due = cyc + 1;
    x.tag = tag;
    x.o   = e;
    q.push_back(x);
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    cmd_halt  = 1'b0;
  endtask

  task automatic compare_loop();
    exp_t  x;
    outs_t a;
    forever begin
      @(negedge clk);
      a = {cpu_rst, cpu_par, in_ready, busy, running, err, wdog_trip};
      if (cpu_rst == 2'b01) begin
        n01++;
        par_log.push_back(cpu_par);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        ntests++;
        if (x.due < cyc) begin
          nfail++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", x.tag, x.due, cyc);
        end else if (a !== x.o) begin
          nfail++;
          $display("FAIL %s @%0d: got rst=%b par=%h rdy=%b busy=%b run=%b err=%b trip=%b want rst=%b par=%h rdy=%b busy=%b run=%b err=%b trip=%b",
                   x.tag, cyc, a.r, a.par, a.rdy, a.busy, a.run, a.err, a.trip,
                   x.o.r, x.o.par, x.o.rdy, x.o.busy, x.o.run, x.o.err, x.o.trip);
        end
      end
    end
  endtask

  // Stream image words from img; n_send < n_total produces an underrun.
  task automatic feed(int n_total, int n_send, int start_at);
    for (int k = 0; k < n_send; k++) begin
      in_valid = 1'b1;
      in_data  = img[k];
      if (k == start_at) cmd_start = 1'b1;
      step("load_word", e_w(img[k], (k < n_total - 1)));
    end
    in_valid = 1'b0;
    if (n_send < n_total) begin
      step("underrun", e_err());
    end else begin
      step("gap", e_gap(1'b0));
      step("run_entry", e_run());
    end
  endtask

  task automatic send_hdr(string tag, int n, outs_t e);
    in_valid = 1'b1;
    in_data  = 16'(n);
    step(tag, e);
    in_valid = 1'b0;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    rst = 1'b1; cmd_start = 1'b0; cmd_halt = 1'b0;
    in_valid = 1'b0; in_data = 16'h0; cpu_evt = 1'b0;
    repeat (3) step("reset", e_idle(1'b0));
    rst = 1'b0;

    // Words offered while in_ready=0 are ignored.
    in_valid = 1'b1; in_data = 16'hBEEF;
    step("idle_ignore", e_idle(1'b0));
    in_valid = 1'b0;
    step("idle", e_idle(1'b0));
    chk("reset_cpu_rst", cpu_rst, 0);

    // Back-to-back load of three words.
    img = '{16'h1111, 16'h2222, 16'h3333};
    n01 = 0;
    par_log.delete();
    cmd_start = 1'b1;
    step("start", e_hdr());
    send_hdr("hdr3", 3, e_loadw());
    feed(3, 3, -1);
    chk("b2b_n01", n01, 3);
    chk("b2b_w0", par_log[0], 16'h1111);
    chk("b2b_w1", par_log[1], 16'h2222);
    chk("b2b_w2", par_log[2], 16'h3333);
    chk("b2b_running", running, 1);
    chk("b2b_cpu_rst", cpu_rst, 3);
    repeat (5) step("run", e_run());

`ifdef CPU_BOOT_WDOG_EN
    for (int i = 0; i < 40; i++) begin
      cpu_evt = (i % 10 == 9);
      step("wdog_kicked", e_run());
    end
    cpu_evt = 1'b0;
`else
    repeat (300) step("run_hold", e_run());
    chk("no_wdog_trip", wdog_trip, 0);
`endif

    // cmd_start in RUN restarts a download; then underrun after 2 of 4 words.
    cmd_start = 1'b1;
    step("run_restart", e_hdr());
    img = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    send_hdr("hdr4", 4, e_loadw());
    feed(4, 2, -1);
    chk("underrun_err", err, 1);
    chk("underrun_cpu_rst", cpu_rst, 0);
    repeat (2) step("err_hold", e_err());
    cmd_halt = 1'b1;
    step("halt_in_err", e_idle(1'b1));
    cmd_start = 1'b1;
    step("start_clears_err", e_hdr());
    chk("err_cleared", err, 0);

    // Bad headers: 0 and MAX_WORDS+1.
    send_hdr("hdr0", 0, e_err());
    step("err", e_err());
    cmd_start = 1'b1;
    step("start", e_hdr());
    send_hdr("hdr_max_plus1", MAXW + 1, e_err());
    chk("hdr_max_plus1_err", err, 1);

    // Full-size image; cmd_start during LOAD is ignored.
    cmd_start = 1'b1;
    step("start", e_hdr());
    img.delete();
    for (int k = 0; k < MAXW; k++) img.push_back(16'(k * 7 + 256));
    send_hdr("hdr_max", MAXW, e_loadw());
    n01 = 0;
    feed(MAXW, MAXW, 5);
    chk("max_n01", n01, 1024);
    chk("max_running", running, 1);

    // Halt on the second LOAD cycle.
    cmd_start = 1'b1;
    step("run_restart2", e_hdr());
    img = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};
    send_hdr("hdr4b", 4, e_loadw());
    in_valid = 1'b1; in_data = img[0];
    step("load_w0", e_w(img[0], 1'b1));
    in_data = img[1]; cmd_halt = 1'b1;
    step("halt_load", e_idle(1'b0));
    in_valid = 1'b0;
    chk("halt_err", err, 0);
    chk("halt_cpu_rst", cpu_rst, 0);

    // Halt and start together in IDLE: halt wins.
    cmd_halt = 1'b1; cmd_start = 1'b1;
    step("halt_start", e_idle(1'b0));
    step("idle", e_idle(1'b0));

`ifdef CPU_BOOT_WDOG_EN
    cmd_start = 1'b1;
    step("start", e_hdr());
    img = '{16'h7001, 16'h7002};
    send_hdr("hdr2", 2, e_loadw());
    feed(2, 2, -1);
    repeat (15) step("wdog_count", e_run());
    step("wdog_trip", e_gap(1'b1));
    chk("trip_pulse", wdog_trip, 1);
    chk("trip_cpu_rst", cpu_rst, 0);
    step("wdog_rerun", e_run());
    chk("trip_rerun", cpu_rst, 3);
    step("run", e_run());
`endif

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
